// File: rtl/coproc_pkg.sv
// Shared coprocessor definitions: opcode encodings, issuer state encoding, frame geometry.
package coproc_pkg;

  localparam logic [2:0] OP_NOP         = 3'd0;
  localparam logic [2:0] OP_LOAD        = 3'd1;
  localparam logic [2:0] OP_STORE       = 3'd2;
  localparam logic [2:0] OP_ZOOM_IN_VP  = 3'd3;
  localparam logic [2:0] OP_ZOOM_IN_RP  = 3'd4;
  localparam logic [2:0] OP_ZOOM_OUT_MP = 3'd5;
  localparam logic [2:0] OP_ZOOM_OUT_VD = 3'd6;
  localparam logic [2:0] OP_RESET_INST  = 3'd7;

  // 320x240 frame, last valid pixel address
  localparam int DEFAULT_MAX_ADDR  = 76799;
  localparam int RESET_INST_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  function automatic logic is_burst_op(input logic [2:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: rise_o is combinational from level_i against its value one cycle earlier.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level_i;
  end

  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/cmd_issuer.sv
// Splits commands into coprocessor beats; ENABLE 2 cycles after accept, rsp 1 cycle after FLAG_DONE rise, no rsp backpressure.
// cmd_ready only in IDLE. Define CMD_TIMEOUT_EN for the per-beat watchdog and the sticky err_timeout port.
module cmd_issuer
  import coproc_pkg::*;
#(
  parameter int MAX_ADDR       = DEFAULT_MAX_ADDR,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [17:0] cmd_addr,
  input  logic [16:0] cmd_len,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [7:0]  px_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_last,
  output logic        busy,
  output logic [2:0]  INSTRUCTION,
  output logic [17:0] MEM_ADDR,
  output logic [7:0]  DATA_IN,
  output logic        ENABLE,
  input  logic [7:0]  DATA_OUT,
`ifdef CMD_TIMEOUT_EN
  output logic        err_timeout,
`endif
  input  logic        FLAG_DONE
);

  // One wait counter serves both the fixed RESET_INST delay and the watchdog
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = (TW > 3) ? TW : 3;

  state_t        state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [17:0]   addr_q, addr_d;
  logic [16:0]   rem_q, rem_d;
  logic [7:0]    din_q, din_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          flag_rise;
  logic          done;
  logic          abort_now;

`ifdef CMD_TIMEOUT_EN
  logic abort_q, abort_d;
  logic err_q, err_d;
  logic timeout;
`endif

  edge_detect u_flag_edge (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .level_i (FLAG_DONE),
    .rise_o  (flag_rise)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      wcnt_q  <= wcnt_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign abort_now   = abort_q;
  assign err_timeout = err_q;
`else
  assign abort_now   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    wcnt_d  = '0;
    done    = 1'b0;
`ifdef CMD_TIMEOUT_EN
    abort_d = abort_q;
    err_d   = err_q;
    timeout = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          addr_d  = cmd_addr;
          din_d   = '0;
          rem_d   = (is_burst_op(cmd_op) && (cmd_len != '0)) ? cmd_len : 17'd1;
          state_d = ST_FETCH;
`ifdef CMD_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      ST_FETCH: begin
        if (op_q != OP_STORE) begin
          state_d = ST_ISSUE;
        end else if (px_valid) begin
          din_d   = px_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        wcnt_d = wcnt_q + 1'b1;
        if (op_q == OP_RESET_INST) done = (wcnt_q == CW'(RESET_INST_CYCLES - 1));
        else                       done = flag_rise;
`ifdef CMD_TIMEOUT_EN
        timeout = !done && (wcnt_q == CW'(TIMEOUT_CYCLES - 1));
`endif
        if (done) begin
          rdata_d = (op_q == OP_LOAD) ? DATA_OUT : 8'h00;
          state_d = ST_RESP;
        end
`ifdef CMD_TIMEOUT_EN
        else if (timeout) begin
          rdata_d = 8'h00;
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (abort_now || (rem_q == 17'd1)) begin
          state_d = ST_IDLE;
        end else begin
          rem_d   = rem_q - 17'd1;
          addr_d  = (addr_q == 18'(MAX_ADDR)) ? 18'd0 : addr_q + 18'd1;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign px_ready    = (state_q == ST_FETCH) && (op_q == OP_STORE);
  assign ENABLE      = (state_q == ST_ISSUE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_last    = rsp_valid && ((rem_q == 17'd1) || abort_now);
  assign rsp_data    = rdata_q;
  assign INSTRUCTION = op_q;
  assign MEM_ADDR    = addr_q;
  assign DATA_IN     = din_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed and randomized bench for cmd_issuer; expected beats come from address/length arithmetic per command.
module tb_cmd_issuer;
  import coproc_pkg::*;

  localparam int MAXA = 76799;
  localparam int TMO  = 16;

  logic        CLOCK_50  = 1'b0;
  logic        RESET_N   = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op    = '0;
  logic [17:0] cmd_addr  = '0;
  logic [16:0] cmd_len   = '0;
  logic        px_valid  = 1'b0;
  logic [7:0]  px_data   = '0;
  logic [7:0]  DATA_OUT  = '0;
  logic        FLAG_DONE = 1'b0;

  logic        cmd_ready, px_ready, rsp_valid, rsp_last, busy, ENABLE;
  logic [7:0]  rsp_data, DATA_IN;
  logic [2:0]  INSTRUCTION;
  logic [17:0] MEM_ADDR;
`ifdef CMD_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cmd_issuer #(.MAX_ADDR(MAXA), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .px_valid    (px_valid),
    .px_ready    (px_ready),
    .px_data     (px_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .busy        (busy),
    .INSTRUCTION (INSTRUCTION),
    .MEM_ADDR    (MEM_ADDR),
    .DATA_IN     (DATA_IN),
    .ENABLE      (ENABLE),
    .DATA_OUT    (DATA_OUT),
`ifdef CMD_TIMEOUT_EN
    .err_timeout (err_timeout),
`endif
    .FLAG_DONE   (FLAG_DONE)
  );

  initial forever #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called from WAIT_DONE of the second beat of a burst
  task automatic reset_mid_burst();
    int n_rsp;
    #3 RESET_N = 1'b0;
    #1;
    check_eq("rst_ctrl_zero", {ENABLE, rsp_valid, rsp_last, busy, px_ready, INSTRUCTION}, 0);
    check_eq("rst_data_zero", {rsp_data, DATA_IN}, 0);
    check_eq("rst_addr_zero", MEM_ADDR, 0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check_eq("cmd_ready_after_rst", cmd_ready, 1);
    n_rsp = 0;
    FLAG_DONE = 1'b1;
    @(negedge CLOCK_50);
    FLAG_DONE = 1'b0;
    repeat (6) begin
      n_rsp += int'(rsp_valid);
      @(negedge CLOCK_50);
    end
    check_eq("no_rsp_after_rst", n_rsp, 0);
    check_eq("idle_after_rst", busy, 0);
  endtask

  // mode: 0 normal, 1 FLAG_DONE already high at ISSUE, 2 reset in beat 2, 3 watchdog expiry
  task automatic run_cmd(input logic [2:0] op, input int addr, input int len,
                         input int mode, input int fix_dly, input int fix_dat);
    int nbeats, a, cyc, n_rsp, dly;
    logic [7:0] pix, dout;
    nbeats = (op == OP_LOAD || op == OP_STORE) ? ((len == 0) ? 1 : len) : 1;
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = 18'(addr);
    cmd_len   = 17'(len);
    if (mode == 1) FLAG_DONE = 1'b1;
    @(negedge CLOCK_50);
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_addr  = 18'($urandom);
    cmd_len   = 17'($urandom);
    check_eq("busy_after_accept", busy, 1);
    check_eq("cmd_ready_busy", cmd_ready, 0);
    for (int k = 0; k < nbeats; k++) begin
      a    = (addr + k) % (MAXA + 1);
      pix  = (fix_dat >= 0) ? 8'(fix_dat * (k + 1)) : 8'($urandom);
      dout = (fix_dat >= 0) ? 8'(fix_dat) : 8'($urandom);
      if (op == OP_STORE) begin
        cyc = $urandom_range(0, 2);
        repeat (cyc) begin
          check_eq("px_ready_stall", px_ready, 1);
          @(negedge CLOCK_50);
        end
        check_eq("px_ready", px_ready, 1);
        px_valid = 1'b1;
        px_data  = pix;
        @(negedge CLOCK_50);
        px_valid = 1'b0;
        px_data  = 8'($urandom);
      end else begin
        check_eq("px_ready_nonstore", px_ready, 0);
      end
      cyc = 0;
      while (!ENABLE && cyc < 20) begin
        @(negedge CLOCK_50);
        cyc++;
      end
      check_eq("enable_seen", ENABLE, 1);
      if (!ENABLE) return;
      check_eq("enable_latency", cyc, (op == OP_STORE) ? 0 : 1);
      check_eq("instruction", INSTRUCTION, op);
      check_eq("mem_addr", MEM_ADDR, a);
      if (op == OP_STORE) check_eq("data_in", DATA_IN, pix);
      @(negedge CLOCK_50);
      check_eq("enable_one_cycle", ENABLE, 0);
      if (mode == 2 && k == 1) begin
        reset_mid_burst();
        return;
      end
      n_rsp = 0;
      if (op == OP_RESET_INST) begin
        repeat (4) begin
          n_rsp += int'(rsp_valid);
          FLAG_DONE = 1'($urandom);
          @(negedge CLOCK_50);
        end
        FLAG_DONE = 1'b0;
        check_eq("reset_inst_wait", n_rsp, 0);
      end
`ifdef CMD_TIMEOUT_EN
      else if (mode == 3) begin
        repeat (TMO) begin
          n_rsp += int'(rsp_valid);
          @(negedge CLOCK_50);
        end
        check_eq("timeout_no_early_rsp", n_rsp, 0);
        check_eq("timeout_rsp_valid", rsp_valid, 1);
        check_eq("timeout_rsp_last", rsp_last, 1);
        check_eq("err_timeout_set", err_timeout, 1);
        @(negedge CLOCK_50);
        check_eq("timeout_idle", busy, 0);
        check_eq("err_timeout_sticky", err_timeout, 1);
        return;
      end
`endif
      else begin
        if (mode == 1) begin
          repeat (3) begin
            n_rsp += int'(rsp_valid);
            @(negedge CLOCK_50);
          end
          FLAG_DONE = 1'b0;
          repeat (2) begin
            n_rsp += int'(rsp_valid);
            @(negedge CLOCK_50);
          end
          check_eq("held_level_ignored", n_rsp, 0);
        end
        dly = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 5);
        repeat (dly) begin
          n_rsp += int'(rsp_valid);
          @(negedge CLOCK_50);
        end
        check_eq("no_early_rsp", n_rsp, 0);
        check_eq("instr_stable", INSTRUCTION, op);
        check_eq("addr_stable", MEM_ADDR, a);
        if (op == OP_STORE) check_eq("data_in_stable", DATA_IN, pix);
        FLAG_DONE = 1'b1;
        DATA_OUT  = dout;
        @(negedge CLOCK_50);
        FLAG_DONE = 1'b0;
        DATA_OUT  = 8'($urandom);
      end
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_last", rsp_last, (k == nbeats - 1));
      check_eq("rsp_data", rsp_data, (op == OP_LOAD) ? dout : 8'h00);
      @(negedge CLOCK_50);
      check_eq("rsp_one_cycle", rsp_valid, 0);
    end
    check_eq("idle_after_cmd", busy, 0);
  endtask

  initial begin
    logic [2:0] rop;
    int raddr, rlen;
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_enable", ENABLE, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_mem_addr", MEM_ADDR, 0);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check_eq("rst_cmd_ready", cmd_ready, 1);

    run_cmd(OP_LOAD, 100, 1, 0, 6, 8'h5A);
    run_cmd(OP_STORE, 76798, 3, 0, -1, 8'h11);
    run_cmd(3'b100, 1234, 500, 0, -1, -1);
    run_cmd(OP_LOAD, 500, 1, 1, 0, -1);
    run_cmd(OP_RESET_INST, 7, 9, 0, -1, -1);
    run_cmd(OP_LOAD, 2000, 5, 2, -1, 8'hA5);
`ifdef CMD_TIMEOUT_EN
    run_cmd(OP_LOAD, 3000, 3, 3, -1, -1);
`endif

    for (int i = 0; i < 30; i++) begin
      rop   = 3'($urandom_range(0, 7));
      raddr = ($urandom_range(0, 3) == 0) ? MAXA - int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, MAXA));
      rlen  = (rop == OP_LOAD || rop == OP_STORE) ? int'($urandom_range(0, 4))
                                                  : int'($urandom_range(0, 1000));
      run_cmd(rop, raddr, rlen, 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete within the time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "time limit reached");
  end

endmodule
